// File: rtl/updownstream_order_tracker.sv
// updownstream_order_tracker
// Per-client order book between the CPU order path and the exchange feedback
// path. Each client has an accumulated order amount, a maximum and a running
// cancelled total. CPU orders are accepted or rejected against the client's
// maximum, and exchange cancellations are applied. Results are registered and
// reported one cycle after the request is sampled.
// Optional feature macro: UPDOWNSTREAM_REJECT_CNT_EN adds a saturating 16-bit
// reject_count output.

module updownstream_order_tracker #(
  parameter int NUM_CLIENTS = 32,
  parameter int CID_W       = 5,
  parameter int AMT_W       = 32,
  parameter int XAMT_W      = 16,
  parameter logic [AMT_W-1:0] MAX_RESET = {AMT_W{1'b1}}
) (
  input  logic              clk,
  input  logic              HRESETn,
  input  logic              cpu_go,
  input  logic              cpu_new_max,
  input  logic [CID_W-1:0]  cpu_client_id,
  input  logic [AMT_W-1:0]  cpu_amount,
  input  logic              exchange_go,
  input  logic [CID_W-1:0]  exchange_client_id,
  input  logic [XAMT_W-1:0] exchange_amount,
  output logic [AMT_W-1:0]  accumulated_orders,
  output logic              cpu_valid,
  output logic              cpu_reject,
  output logic [XAMT_W-1:0] cancelled_orders,
  output logic              exchange_valid
`ifdef UPDOWNSTREAM_REJECT_CNT_EN
  ,
  output logic [15:0]       reject_count
`endif
);

  // The tables span the whole id space so any id can index them safely;
  // entries at or above NUM_CLIENTS are never written and stay constant.
  localparam int DEPTH = 1 << CID_W;
  localparam logic [CID_W:0] NUM_CLIENTS_W = (CID_W+1)'(NUM_CLIENTS);

  logic [AMT_W-1:0]  acc_q [DEPTH];
  logic [AMT_W-1:0]  acc_d [DEPTH];
  logic [AMT_W-1:0]  max_q [DEPTH];
  logic [AMT_W-1:0]  max_d [DEPTH];
  logic [XAMT_W-1:0] cxl_q [DEPTH];
  logic [XAMT_W-1:0] cxl_d [DEPTH];

  logic [AMT_W-1:0]  accOut_q, accOut_d;
  logic              cpuValid_q, cpuValid_d;
  logic              cpuReject_q, cpuReject_d;
  logic [XAMT_W-1:0] cxlOut_q, cxlOut_d;
  logic              exValid_q, exValid_d;

  logic              exInRange;
  logic              cpuInRange;
  logic [AMT_W-1:0]  exAccOld;
  logic [AMT_W-1:0]  exAmtExt;
  logic [AMT_W-1:0]  exDec;
  logic [AMT_W-1:0]  exAccNew;
  logic [XAMT_W:0]   cxlSum;
  logic [XAMT_W-1:0] cxlNew;
  logic [AMT_W-1:0]  cpuBase;
  logic [AMT_W:0]    cpuSum;
  logic              cpuFits;

  // Next-state for the client tables and result registers. The exchange is
  // resolved first so a same-client CPU request sees the post-cancel amount.
  always_comb begin
    acc_d       = acc_q;
    max_d       = max_q;
    cxl_d       = cxl_q;
    accOut_d    = accOut_q;
    cxlOut_d    = cxlOut_q;
    cpuValid_d  = 1'b0;
    cpuReject_d = 1'b0;
    exValid_d   = 1'b0;

    exInRange  = {1'b0, exchange_client_id} < NUM_CLIENTS_W;
    cpuInRange = {1'b0, cpu_client_id} < NUM_CLIENTS_W;

    // Cancellation is clipped to the outstanding amount; the cancelled total
    // saturates rather than wrapping.
    exAccOld = acc_q[exchange_client_id];
    exAmtExt = AMT_W'(exchange_amount);
    exDec    = (exAmtExt < exAccOld) ? exAmtExt : exAccOld;
    exAccNew = exAccOld - exDec;
    cxlSum   = {1'b0, cxl_q[exchange_client_id]} + {1'b0, exDec[XAMT_W-1:0]};
    cxlNew   = cxlSum[XAMT_W] ? {XAMT_W{1'b1}} : cxlSum[XAMT_W-1:0];

    if (exchange_go) begin
      exValid_d = 1'b1;
      if (exInRange) begin
        acc_d[exchange_client_id] = exAccNew;
        cxl_d[exchange_client_id] = cxlNew;
        cxlOut_d = cxlNew;
      end else begin
        cxlOut_d = '0;
      end
    end

    // The extra carry bit in the sum makes any wrapping order exceed max.
    cpuBase = (exchange_go && exInRange && (exchange_client_id == cpu_client_id))
              ? exAccNew : acc_q[cpu_client_id];
    cpuSum  = {1'b0, cpuBase} + {1'b0, cpu_amount};
    cpuFits = cpuSum <= {1'b0, max_q[cpu_client_id]};

    if (cpu_go) begin
      cpuValid_d = 1'b1;
      if (!cpuInRange) begin
        cpuReject_d = 1'b1;
        accOut_d    = '0;
      end else if (cpu_new_max) begin
        max_d[cpu_client_id] = cpu_amount;
        accOut_d = cpuBase;
      end else if (cpuFits) begin
        acc_d[cpu_client_id] = cpuSum[AMT_W-1:0];
        accOut_d = cpuSum[AMT_W-1:0];
      end else begin
        cpuReject_d = 1'b1;
        accOut_d    = cpuBase;
      end
    end
  end

  // Register client tables and per-request results; reset clears everything.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        acc_q[i] <= '0;
        max_q[i] <= MAX_RESET;
        cxl_q[i] <= '0;
      end
      accOut_q    <= '0;
      cpuValid_q  <= 1'b0;
      cpuReject_q <= 1'b0;
      cxlOut_q    <= '0;
      exValid_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      max_q       <= max_d;
      cxl_q       <= cxl_d;
      accOut_q    <= accOut_d;
      cpuValid_q  <= cpuValid_d;
      cpuReject_q <= cpuReject_d;
      cxlOut_q    <= cxlOut_d;
      exValid_q   <= exValid_d;
    end
  end

  assign accumulated_orders = accOut_q;
  assign cpu_valid          = cpuValid_q;
  assign cpu_reject         = cpuValid_q & cpuReject_q;
  assign cancelled_orders   = cxlOut_q;
  assign exchange_valid     = exValid_q;

`ifdef UPDOWNSTREAM_REJECT_CNT_EN
  logic [15:0] rejCnt_q;

  // Count registered rejects, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      rejCnt_q <= '0;
    end else if (cpuValid_d && cpuReject_d && (rejCnt_q != 16'hFFFF)) begin
      rejCnt_q <= rejCnt_q + 16'd1;
    end
  end

  assign reject_count = rejCnt_q;
`endif

endmodule

// File: tb/tb_updownstream_order_tracker.sv
// Testbench for updownstream_order_tracker (built with NUM_CLIENTS=20).
// Stimulus pushes expected results into queues; a negedge monitor pops and
// compares whenever the DUT raises cpu_valid or exchange_valid.

module tb_updownstream_order_tracker;

  localparam int NUM_CLIENTS = 20;
  localparam int CID_W       = 5;
  localparam int AMT_W       = 32;
  localparam int XAMT_W      = 16;

  logic              clk = 1'b0;
  logic              HRESETn;
  logic              cpu_go;
  logic              cpu_new_max;
  logic [CID_W-1:0]  cpu_client_id;
  logic [AMT_W-1:0]  cpu_amount;
  logic              exchange_go;
  logic [CID_W-1:0]  exchange_client_id;
  logic [XAMT_W-1:0] exchange_amount;
  logic [AMT_W-1:0]  accumulated_orders;
  logic              cpu_valid;
  logic              cpu_reject;
  logic [XAMT_W-1:0] cancelled_orders;
  logic              exchange_valid;
`ifdef UPDOWNSTREAM_REJECT_CNT_EN
  logic [15:0]       reject_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic             rej;
    logic [AMT_W-1:0] acc;
  } cpuExp_t;

  cpuExp_t           cpuQ[$];
  logic [XAMT_W-1:0] exQ[$];
  cpuExp_t           cpuE;
  logic [XAMT_W-1:0] exE;

  updownstream_order_tracker #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .CID_W(CID_W),
    .AMT_W(AMT_W),
    .XAMT_W(XAMT_W)
  ) dut (
    .clk(clk),
    .HRESETn(HRESETn),
    .cpu_go(cpu_go),
    .cpu_new_max(cpu_new_max),
    .cpu_client_id(cpu_client_id),
    .cpu_amount(cpu_amount),
    .exchange_go(exchange_go),
    .exchange_client_id(exchange_client_id),
    .exchange_amount(exchange_amount),
    .accumulated_orders(accumulated_orders),
    .cpu_valid(cpu_valid),
    .cpu_reject(cpu_reject),
    .cancelled_orders(cancelled_orders),
    .exchange_valid(exchange_valid)
`ifdef UPDOWNSTREAM_REJECT_CNT_EN
    ,
    .reject_count(reject_count)
`endif
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests just after a rising edge and queue the results.
  task automatic applyStimulus(
    input logic              cGo,
    input logic              cNew,
    input logic [CID_W-1:0]  cId,
    input logic [AMT_W-1:0]  cAmt,
    input logic              xGo,
    input logic [CID_W-1:0]  xId,
    input logic [XAMT_W-1:0] xAmt,
    input logic              expRej,
    input logic [AMT_W-1:0]  expAcc,
    input logic [XAMT_W-1:0] expCxl
  );
    cpuExp_t e;
    @(posedge clk);
    #1;
    cpu_go             = cGo;
    cpu_new_max        = cNew;
    cpu_client_id      = cId;
    cpu_amount         = cAmt;
    exchange_go        = xGo;
    exchange_client_id = xId;
    exchange_amount    = xAmt;
    if (cGo) begin
      e.rej = expRej;
      e.acc = expAcc;
      cpuQ.push_back(e);
    end
    if (xGo) exQ.push_back(expCxl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cpu_go      = 1'b0;
      exchange_go = 1'b0;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_acc"}, 64'(accumulated_orders), 64'd0);
    checkOutput({tag, "_cpu_valid"}, 64'(cpu_valid), 64'd0);
    checkOutput({tag, "_cpu_reject"}, 64'(cpu_reject), 64'd0);
    checkOutput({tag, "_cxl"}, 64'(cancelled_orders), 64'd0);
    checkOutput({tag, "_ex_valid"}, 64'(exchange_valid), 64'd0);
`ifdef UPDOWNSTREAM_REJECT_CNT_EN
    checkOutput({tag, "_reject_count"}, 64'(reject_count), 64'd0);
`endif
  endtask

  // Monitor: compare every presented result against the head of its queue.
  always @(negedge clk) begin
    if (HRESETn) begin
      if (cpu_valid) begin
        if (cpuQ.size() == 0) begin
          checkOutput("cpu_unexpected_valid", 64'd1, 64'd0);
        end else begin
          cpuE = cpuQ.pop_front();
          checkOutput("cpu_reject", 64'(cpu_reject), 64'(cpuE.rej));
          checkOutput("accumulated_orders", 64'(accumulated_orders), 64'(cpuE.acc));
        end
      end
      if (exchange_valid) begin
        if (exQ.size() == 0) begin
          checkOutput("ex_unexpected_valid", 64'd1, 64'd0);
        end else begin
          exE = exQ.pop_front();
          checkOutput("cancelled_orders", 64'(cancelled_orders), 64'(exE));
        end
      end
    end
  end

  initial begin
    HRESETn            = 1'b0;
    cpu_go             = 1'b0;
    cpu_new_max        = 1'b0;
    cpu_client_id      = '0;
    cpu_amount         = '0;
    exchange_go        = 1'b0;
    exchange_client_id = '0;
    exchange_amount    = '0;
    #1;
    checkResetOutputs("reset0");
    #11;
    HRESETn = 1'b1;

    // Basic order on client 3
    applyStimulus(1, 0, 5'd3, 32'd100, 0, 5'd0, 16'd0, 0, 32'd100, 16'd0);
    // Set max, reject over-limit order, accept exact fit
    applyStimulus(1, 1, 5'd3, 32'd150, 0, 5'd0, 16'd0, 0, 32'd100, 16'd0);
    applyStimulus(1, 0, 5'd3, 32'd60,  0, 5'd0, 16'd0, 1, 32'd100, 16'd0);
    applyStimulus(1, 0, 5'd3, 32'd50,  0, 5'd0, 16'd0, 0, 32'd150, 16'd0);
    // Over-cancel clips to accumulated amount
    applyStimulus(0, 0, 5'd0, 32'd0,   1, 5'd3, 16'd200, 0, 32'd0, 16'd150);
    applyStimulus(1, 0, 5'd3, 32'd0,   0, 5'd0, 16'd0, 0, 32'd0, 16'd0);
    // Client 7: same-cycle exchange and order
    applyStimulus(1, 1, 5'd7, 32'd100, 0, 5'd0, 16'd0, 0, 32'd0, 16'd0);
    applyStimulus(1, 0, 5'd7, 32'd80,  0, 5'd0, 16'd0, 0, 32'd80, 16'd0);
    applyStimulus(1, 0, 5'd7, 32'd40,  1, 5'd7, 16'd30, 0, 32'd90, 16'd30);
    applyStimulus(0, 0, 5'd0, 32'd0,   1, 5'd7, 16'd0, 0, 32'd0, 16'd30);
    // Client 5: full-range order, carry reject, cancelled-total saturation
    applyStimulus(1, 0, 5'd5, 32'hFFFF_FFFF, 0, 5'd0, 16'd0, 0, 32'hFFFF_FFFF, 16'd0);
    applyStimulus(1, 0, 5'd5, 32'd1, 0, 5'd0, 16'd0, 1, 32'hFFFF_FFFF, 16'd0);
    applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd5, 16'hFFFF, 0, 32'd0, 16'hFFFF);
    applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd5, 16'd2, 0, 32'd0, 16'hFFFF);
    // Lower max below acc: zero order now rejects
    applyStimulus(1, 1, 5'd7, 32'd50, 0, 5'd0, 16'd0, 0, 32'd90, 16'd0);
    applyStimulus(1, 0, 5'd7, 32'd0,  0, 5'd0, 16'd0, 1, 32'd90, 16'd0);
    // Set-max and exchange on the same client both apply
    applyStimulus(1, 1, 5'd7, 32'd200, 1, 5'd7, 16'd10, 0, 32'd80, 16'd40);
    applyStimulus(1, 0, 5'd7, 32'd120, 0, 5'd0, 16'd0, 0, 32'd200, 16'd0);
    // Different clients in the same cycle
    applyStimulus(1, 0, 5'd3, 32'd10, 1, 5'd7, 16'd5, 0, 32'd10, 16'd45);
    // Out-of-range ids, then confirm others untouched
    applyStimulus(1, 0, 5'd25, 32'd5, 1, 5'd25, 16'd7, 1, 32'd0, 16'd0);
    applyStimulus(1, 0, 5'd3, 32'd0, 1, 5'd3, 16'd0, 0, 32'd10, 16'd150);
    applyStimulus(1, 0, 5'd7, 32'd0, 1, 5'd5, 16'd0, 0, 32'd195, 16'hFFFF);
    idle(3);
`ifdef UPDOWNSTREAM_REJECT_CNT_EN
    checkOutput("reject_count_pre", 64'(reject_count), 64'd4);
`endif

    // Mid-stream reset, asserted between edges with a request in flight
    applyStimulus(1, 0, 5'd3, 32'd5, 0, 5'd0, 16'd0, 0, 32'd15, 16'd0);
    idle(2);
    @(posedge clk);
    #1;
    cpu_go        = 1'b1;
    cpu_new_max   = 1'b0;
    cpu_client_id = 5'd7;
    cpu_amount    = 32'd1;
    #2;
    HRESETn = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    cpu_go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("held_reset");
    @(negedge clk);
    #2;
    HRESETn = 1'b1;

    // After reset: accumulators cleared and max back to reset value
    applyStimulus(1, 0, 5'd3, 32'd1, 0, 5'd0, 16'd0, 0, 32'd1, 16'd0);
    applyStimulus(1, 0, 5'd3, 32'hFFFF_FFFE, 1, 5'd7, 16'd3, 0, 32'hFFFF_FFFF, 16'd0);
    applyStimulus(1, 0, 5'd25, 32'd1, 0, 5'd0, 16'd0, 1, 32'd0, 16'd0);
    idle(3);
`ifdef UPDOWNSTREAM_REJECT_CNT_EN
    checkOutput("reject_count_post", 64'(reject_count), 64'd1);
`endif

    // Bounded drain of anything still expected
    for (int i = 0; i < 20; i++) begin
      if (cpuQ.size() == 0 && exQ.size() == 0) break;
      @(posedge clk);
    end
    checkOutput("cpu_queue_drained", 64'(cpuQ.size()), 64'd0);
    checkOutput("ex_queue_drained", 64'(exQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
